// File: rtl/simmem_linkedlist_resp_bank.sv
// rtl/simmem_linkedlist_resp_bank.sv - shared-RAM response bank with per-ID linked lists
// Responses are chained per ID so each ID keeps its order; released heads go out round-robin.
module simmem_linkedlist_resp_bank #(
  parameter int IDWidth       = 4,
  parameter int DataWidth     = 3,
  parameter int TotalCapacity = 32
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [IDWidth+DataWidth-1:0]         in_data_i,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  input  logic [2**IDWidth-1:0]                release_en_i,
  output logic [IDWidth+DataWidth-1:0]         out_data_o,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic [$clog2(TotalCapacity+1)-1:0]   free_count_o
);

  localparam int NumIds    = 2**IDWidth;
  localparam int AddrWidth = $clog2(TotalCapacity);
  localparam int CntWidth  = $clog2(TotalCapacity+1);
  localparam int W         = IDWidth + DataWidth;

  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [CntWidth-1:0]  cnt_t;
  typedef logic [IDWidth-1:0]   id_t;

  logic [W-1:0] mem      [TotalCapacity];
  addr_t        next_ptr [TotalCapacity];
  addr_t        head     [NumIds];
  addr_t        tail     [NumIds];
  cnt_t         len      [NumIds];
  addr_t        free_head, free_tail;
  cnt_t         free_count;
  id_t          rr_ptr, lock_id;
  logic         lock;

  logic [NumIds-1:0] eligible, push_vec, pop_vec;
  id_t               rr_sel, idx, sel, in_id;
  logic              found, accept, handshake;
  addr_t             new_slot, pop_slot;

  always_comb begin
    for (int k = 0; k < NumIds; k++) begin
      eligible[k] = (len[k] != '0) && release_en_i[k];
    end
  end

  // Round-robin scan starting at rr_ptr; the id_t add wraps modulo NumIds.
  always_comb begin
    rr_sel = rr_ptr;
    found  = 1'b0;
    idx    = rr_ptr;
    for (int i = 0; i < NumIds; i++) begin
      idx = rr_ptr + id_t'(i);
      if (!found && eligible[idx]) begin
        rr_sel = idx;
        found  = 1'b1;
      end
    end
  end

  assign sel          = lock ? lock_id : rr_sel;
  assign out_valid_o  = lock || found;
  assign out_data_o   = out_valid_o ? mem[head[sel]] : '0;
  assign in_ready_o   = rst_ni && (free_count != '0);
  assign free_count_o = free_count;

  assign in_id     = in_data_i[W-1 -: IDWidth];
  assign accept    = in_valid_i && in_ready_o;
  assign handshake = out_valid_o && out_ready_i;
  assign new_slot  = free_head;
  assign pop_slot  = head[sel];

  always_comb begin
    for (int k = 0; k < NumIds; k++) begin
      push_vec[k] = accept && (in_id == id_t'(k));
      pop_vec[k]  = handshake && (sel == id_t'(k));
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) mem[new_slot] <= in_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int k = 0; k < NumIds; k++) begin
        head[k] <= '0;
        tail[k] <= '0;
        len[k]  <= '0;
      end
      for (int i = 0; i < TotalCapacity; i++) begin
        next_ptr[i] <= addr_t'((i + 1) % TotalCapacity);
      end
      free_head  <= '0;
      free_tail  <= addr_t'(TotalCapacity - 1);
      free_count <= cnt_t'(TotalCapacity);
      rr_ptr     <= '0;
      lock       <= 1'b0;
      lock_id    <= '0;
    end else begin
      if (accept && len[in_id] != '0) next_ptr[tail[in_id]] <= new_slot;
      // The freed slot links behind the free tail unless the free list is (or becomes) empty.
      if (handshake && free_count != '0 && !(accept && free_count == cnt_t'(1)))
        next_ptr[free_tail] <= pop_slot;

      case ({accept, handshake})
        2'b10: free_head <= next_ptr[free_head];
        2'b01: begin
          if (free_count == '0) free_head <= pop_slot;
          free_tail <= pop_slot;
        end
        2'b11: begin
          if (free_count == cnt_t'(1)) free_head <= pop_slot;
          else                         free_head <= next_ptr[free_head];
          free_tail <= pop_slot;
        end
        default: ;
      endcase

      if (accept && !handshake)      free_count <= free_count - cnt_t'(1);
      else if (handshake && !accept) free_count <= free_count + cnt_t'(1);

      for (int k = 0; k < NumIds; k++) begin
        if (pop_vec[k] && push_vec[k] && len[k] == cnt_t'(1)) head[k] <= new_slot;
        else if (pop_vec[k])                                   head[k] <= next_ptr[head[k]];
        else if (push_vec[k] && len[k] == '0)                  head[k] <= new_slot;
        if (push_vec[k]) tail[k] <= new_slot;
        if (push_vec[k] && !pop_vec[k])      len[k] <= len[k] + cnt_t'(1);
        else if (pop_vec[k] && !push_vec[k]) len[k] <= len[k] - cnt_t'(1);
      end

      // A presented but unaccepted response freezes the selection.
      if (handshake) begin
        lock   <= 1'b0;
        rr_ptr <= sel + id_t'(1);
      end else if (out_valid_o) begin
        lock    <= 1'b1;
        lock_id <= sel;
      end
    end
  end

endmodule

// File: tb/tb_simmem_linkedlist_resp_bank.sv
// tb/tb_simmem_linkedlist_resp_bank.sv - directed scoreboard bench for the linked-list response bank
module tb_simmem_linkedlist_resp_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] release_en;
  logic [6:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  free_count;

  int          checks = 0;
  int          errors = 0;
  logic        acc_seen;
  logic [6:0]  sb[$];

  simmem_linkedlist_resp_bank #(.IDWidth(4), .DataWidth(3), .TotalCapacity(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_data_i(in_data), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .release_en_i(release_en), .out_data_o(out_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .free_count_o(free_count)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] mk(input int id, input int d);
    logic [6:0] r;
    r = {id[3:0], d[2:0]};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes at the falling edge, return just after the rising edge.
  task automatic tick();
    logic [6:0] e;
    @(negedge clk);
    acc_seen = in_valid && in_ready;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", {25'd0, out_data}, 32'hffff_ffff);
      end else begin
        e = sb.pop_front();
        chk("out_data", {25'd0, out_data}, {25'd0, e});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1 chk("in_ready_in_reset", {31'd0, in_ready}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    sb.delete();
  endtask

  task automatic push(input int id, input int d);
    int n;
    in_valid = 1'b1;
    in_data  = mk(id, d);
    n = 0;
    acc_seen = 1'b0;
    while (!acc_seen && n < 50) begin
      tick();
      n++;
    end
    chk("push_accepted", {31'd0, acc_seen}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    chk("drain_empty", sb.size(), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; release_en = '0; out_ready = 1'b0;

    // reset state
    do_reset();
    #1;
    chk("rst_free_count", {26'd0, free_count}, 32'd32);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {25'd0, out_data}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // single entry held, then released
    out_ready = 1'b1;
    push(3, 5);
    #1 chk("single_fc_after_push", {26'd0, free_count}, 32'd31);
    repeat (10) tick();
    chk("single_held_valid", {31'd0, out_valid}, 32'd0);
    sb.push_back(mk(3, 5));
    release_en = 16'h0008;
    #1;
    chk("single_valid_same_cycle", {31'd0, out_valid}, 32'd1);
    chk("single_data", {25'd0, out_data}, {25'd0, mk(3, 5)});
    tick();
    release_en = '0;
    #1 chk("single_fc_after_pop", {26'd0, free_count}, 32'd32);

    // per-ID order with round robin from 0
    do_reset();
    out_ready = 1'b0;
    push(2, 1); push(7, 2); push(2, 3); push(7, 4);
    sb.push_back(mk(2, 1)); sb.push_back(mk(7, 2));
    sb.push_back(mk(2, 3)); sb.push_back(mk(7, 4));
    release_en = 16'hffff;
    out_ready  = 1'b1;
    drain(20);
    release_en = '0;

    // full bank
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 32; i++) begin
      in_data = mk(i % 16, i % 8);
      tick();
      chk("full_accept", {31'd0, acc_seen}, 32'd1);
    end
    in_data = mk(5, 7);
    #1;
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("full_fc", {26'd0, free_count}, 32'd0);
    repeat (3) tick();
    chk("full_33rd_held", {31'd0, acc_seen}, 32'd0);
    sb.push_back(mk(0, 0));
    release_en = 16'h0001;
    out_ready  = 1'b1;
    #1 chk("full_ready_during_pop", {31'd0, in_ready}, 32'd0);
    tick();
    release_en = '0;
    #1 chk("full_ready_after_pop", {31'd0, in_ready}, 32'd1);
    tick();
    chk("full_33rd_accept", {31'd0, acc_seen}, 32'd1);
    in_valid = 1'b0;
    #1 chk("full_fc_end", {26'd0, free_count}, 32'd0);

    // lock stability
    do_reset();
    out_ready = 1'b0;
    push(1, 6);
    release_en = 16'h0002;
    #1;
    chk("lock_valid", {31'd0, out_valid}, 32'd1);
    chk("lock_data", {25'd0, out_data}, {25'd0, mk(1, 6)});
    tick();
    release_en = '0;
    in_valid   = 1'b1;
    in_data    = mk(0, 2);
    #1;
    chk("lock_valid_drop", {31'd0, out_valid}, 32'd1);
    chk("lock_data_drop", {25'd0, out_data}, {25'd0, mk(1, 6)});
    tick();
    chk("lock_id0_accept", {31'd0, acc_seen}, 32'd1);
    in_valid   = 1'b0;
    release_en = 16'h0001;
    #1 chk("lock_data_hold", {25'd0, out_data}, {25'd0, mk(1, 6)});
    sb.push_back(mk(1, 6));
    sb.push_back(mk(0, 2));
    out_ready = 1'b1;
    drain(10);
    release_en = '0;

    // simultaneous accept and pop on the same ID
    out_ready = 1'b0;
    push(4, 3);
    #1 chk("simul_fc_before", {26'd0, free_count}, 32'd31);
    sb.push_back(mk(4, 3));
    sb.push_back(mk(4, 5));
    release_en = 16'h0010;
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    in_data    = mk(4, 5);
    tick();
    chk("simul_accept", {31'd0, acc_seen}, 32'd1);
    in_valid = 1'b0;
    #1 chk("simul_fc_unchanged", {26'd0, free_count}, 32'd31);
    drain(5);
    #1 chk("simul_fc_end", {26'd0, free_count}, 32'd32);
    release_en = '0;

    // reset while locked with 10 entries stored
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) push(i, i % 8);
    release_en = 16'hffff;
    tick();
    chk("midrst_locked_valid", {31'd0, out_valid}, 32'd1);
    do_reset();
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_fc", {26'd0, free_count}, 32'd32);
    chk("midrst_out_data", {25'd0, out_data}, 32'd0);
    out_ready = 1'b1;
    repeat (5) tick();
    push(0, 1);
    sb.push_back(mk(0, 1));
    drain(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
